// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch: PC, ROM addressing, IF/ID register, RUN/HALT
//            FSM. Optional backward-taken branch prediction under the macro
//            IF_BTFN_PREDICT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_INST = 32'h00000033
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               ifid_valid,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_pc_plus4,
  output logic [31:0]        ifid_inst,
  output logic               ifid_pred_taken,
  output logic               fetch_halted
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] inst_q, inst_d;
  logic        pred_q, pred_d;

  logic        w_in_range;
  logic        w_pred_taken;
  logic [31:0] w_next_pc;

  // Range test on the full 32-bit PC so high address bits cannot alias into ROM.
  assign w_in_range = (({32'd0, pc_q}) >> 2) < (64'd1 << IMEM_AW);

`ifdef IF_BTFN_PREDICT_EN
  logic [31:0] w_pred_imm;
  assign w_pred_imm   = {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                         imem_data[30:25], imem_data[11:8], 1'b0};
  assign w_pred_taken = (imem_data[6:0] == 7'b1100011) && imem_data[31];
  assign w_next_pc    = w_pred_taken ? (pc_q + w_pred_imm) : (pc_q + 32'd4);
`else
  assign w_pred_taken = 1'b0;
  assign w_next_pc    = pc_q + 32'd4;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_pc4_d = ifid_pc4_q;
    inst_d     = inst_q;
    pred_d     = pred_q;

    if (redirect) begin
      pc_d    = redirect_pc & ~32'h3;
      state_d = S_RUN;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      pred_d  = 1'b0;
    end else if (!stall) begin
      case (state_q)
        S_RUN: begin
          if (w_in_range) begin
            valid_d    = 1'b1;
            ifid_pc_d  = pc_q;
            ifid_pc4_d = pc_q + 32'd4;
            inst_d     = imem_data;
            pred_d     = w_pred_taken;
            pc_d       = w_next_pc;
          end else begin
            state_d = S_HALT;
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            pred_d  = 1'b0;
          end
        end
        default: begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          pred_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      ifid_pc_q  <= 32'd0;
      ifid_pc4_q <= 32'd0;
      inst_q     <= NOP_INST;
      pred_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_pc4_q <= ifid_pc4_d;
      inst_q     <= inst_d;
      pred_q     <= pred_d;
    end
  end

  assign imem_addr       = pc_q[IMEM_AW+1:2];
  assign ifid_valid      = valid_q;
  assign ifid_pc         = ifid_pc_q;
  assign ifid_pc_plus4   = ifid_pc4_q;
  assign ifid_inst       = inst_q;
  assign ifid_pred_taken = pred_q;
  assign fetch_halted    = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

  localparam int          AW  = 6;
  localparam logic [31:0] NOP = 32'h00000033;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          ifid_valid;
  logic [31:0]   ifid_pc;
  logic [31:0]   ifid_pc_plus4;
  logic [31:0]   ifid_inst;
  logic          ifid_pred_taken;
  logic          fetch_halted;

  logic [31:0] rom [1 << AW];

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_inst;
  logic        m_pred;

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  if_fetch_stage #(.IMEM_AW(AW), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_inst      (ifid_inst),
    .ifid_pred_taken(ifid_pred_taken),
    .fetch_halted   (fetch_halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_predicts(input logic [31:0] w);
`ifdef IF_BTFN_PREDICT_EN
    return (w[6:0] == 7'b1100011) && w[31];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] branch_offset(input logic [31:0] w);
    int off;
    off = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    if (w[31]) off = off - 8192;
    return 32'(off);
  endfunction

  // One clock: advance the model from the inputs seen at the edge.
  task automatic model_edge();
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'h0; m_halted = 1'b0; m_valid = 1'b0;
      m_ipc = 32'h0; m_inst = NOP; m_pred = 1'b0;
    end else if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_halted = 1'b0; m_valid = 1'b0; m_inst = NOP; m_pred = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (m_halted || (m_pc / 4) >= (1 << AW)) begin
      m_halted = 1'b1; m_valid = 1'b0; m_inst = NOP; m_pred = 1'b0;
    end else begin
      w = rom[m_pc / 4];
      m_valid = 1'b1; m_ipc = m_pc; m_inst = w; m_pred = model_predicts(w);
      m_pc = m_pred ? m_pc + branch_offset(w) : m_pc + 4;
    end
  endtask

  task automatic compare_all();
    chk("imem_addr",    32'(imem_addr),       32'(m_pc[AW+1:2]));
    chk("fetch_halted", 32'(fetch_halted),    32'(m_halted));
    chk("ifid_valid",   32'(ifid_valid),      32'(m_valid));
    chk("ifid_inst",    ifid_inst,            m_inst);
    chk("ifid_pred",    32'(ifid_pred_taken), 32'(m_pred));
    if (m_valid) begin
      chk("ifid_pc",     ifid_pc,       m_ipc);
      chk("ifid_pc_plus4", ifid_pc_plus4, m_ipc + 32'd4);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_to_addr(input int addr, input string name);
    int n;
    n = 0;
    while (imem_addr != AW'(addr) && n < 64) begin
      step();
      n++;
    end
    chk({name, "_reach"}, 32'(imem_addr), 32'(addr));
  endtask

  initial begin
    logic exp_pred;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 32'h00000013;

    // 1. Reset and first fetch
    rst = 1'b1;
    step();
    step();
    chk("rst_addr",  32'(imem_addr),  32'd0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_inst",  ifid_inst,       NOP);
    chk("rst_pc",    ifid_pc,         32'd0);
    chk("rst_pc4",   ifid_pc_plus4,   32'd0);
    chk("rst_halt",  32'(fetch_halted), 32'd0);
    rst = 1'b0;
    step();
    chk("t1_valid", 32'(ifid_valid), 32'd1);
    chk("t1_pc",    ifid_pc,         32'd0);
    chk("t1_pc4",   ifid_pc_plus4,   32'd4);
    chk("t1_addr",  32'(imem_addr),  32'd1);

    // 2. Stall at pc=0x14
    run_to_addr(5, "t2");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall_addr", 32'(imem_addr), 32'd5);
      chk("t2_stall_pc",   ifid_pc,        32'h10);
    end
    stall = 1'b0;
    step();
    chk("t2_rel_pc",   ifid_pc,        32'h14);
    chk("t2_rel_addr", 32'(imem_addr), 32'd6);

    // 3. Redirect overrides stall
    redirect = 1'b1; redirect_pc = 32'h5C; stall = 1'b1;
    step();
    chk("t3_addr",  32'(imem_addr),  32'd23);
    chk("t3_valid", 32'(ifid_valid), 32'd0);
    chk("t3_inst",  ifid_inst,       32'h00000033);
    redirect = 1'b0; stall = 1'b0;

    // 4. Fall off the end of ROM
    redirect = 1'b1; redirect_pc = 32'hFC;
    step();
    redirect = 1'b0;
    chk("t4_addr_fc", 32'(imem_addr), 32'd63);
    step();
    chk("t4_pc_fc",  ifid_pc,            32'hFC);
    chk("t4_nohalt", 32'(fetch_halted),  32'd0);
    step();
    chk("t4_halt",   32'(fetch_halted),  32'd1);
    chk("t4_valid",  32'(ifid_valid),    32'd0);
    step();
    chk("t4_halt2",  32'(fetch_halted),  32'd1);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk("t4_run",    32'(fetch_halted),  32'd0);
    chk("t4_addr0",  32'(imem_addr),     32'd0);

    // 5. Misaligned redirect, then mid-run reset
    redirect = 1'b1; redirect_pc = 32'h23;
    step();
    redirect = 1'b0;
    chk("t5_addr", 32'(imem_addr), 32'd8);
    run_to_addr(16, "t5");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_addr",  32'(imem_addr),  32'd0);
    chk("t5_rst_valid", 32'(ifid_valid), 32'd0);

    // 6. Backward branch at 0x40
    rom[16] = 32'hFE000EE3;
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    step();
`ifdef IF_BTFN_PREDICT_EN
    exp_pred = 1'b1;
    chk("t6_addr", 32'(imem_addr), 32'd15);
`else
    exp_pred = 1'b0;
    chk("t6_addr", 32'(imem_addr), 32'd17);
`endif
    chk("t6_inst", ifid_inst,             32'hFE000EE3);
    chk("t6_pc",   ifid_pc,               32'h40);
    chk("t6_pred", 32'(ifid_pred_taken),  32'(exp_pred));

    // Randomized phase
    for (int i = 0; i < (1 << AW); i++) begin
      if ($urandom_range(0, 3) == 0)
        rom[i] = {1'b1, 6'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'b1100011};
      else
        rom[i] = $urandom;
    end
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = $urandom;
      else                           redirect_pc = 32'($urandom_range(0, 32'h10F));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
